bcd_field_reducer: RTL

Serial reducer for ten's-complement BCD integers, the inverse of the BCD field extensor. It accepts an N-digit number one digit per handshake, most significant digit first. It returns the low M digits in parallel, plus a flag saying whether dropping the upper N-M digits preserved the value, i.e. whether those digits were pure sign extension. It sits at the narrowing end of BCD datapaths, after wide arithmetic and before narrower storage or display.

---
 rtl/bcd_field_reducer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bcd_field_reducer.sv
// rtl/bcd_field_reducer.sv - serial ten's-complement BCD field reducer (N digits in, M digits out)
//
// Purpose: accepts an N-digit ten's-complement BCD number one digit per
// handshake, MSD first, and returns the low M digits in parallel together
// with a flag telling whether the dropped N-M digits were pure sign extension.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   in_valid/in_ready       digit handshake, in_digit carries one BCD digit
//   out_valid/out_ready     result handshake
//   out_digits [4*M-1:0]    reduced number, digit 0 in bits [3:0]
//   out_fits                value is representable in M digits
//   out_invalid             a non-BCD code was received (only with BCD_REDUCER_CHECK_EN)
//
// Optional feature macro: BCD_REDUCER_CHECK_EN (non-BCD digit detection).

module bcd_field_reducer #(
  parameter int N = 4,
  parameter int M = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_digit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*M-1:0] out_digits,
  output logic           out_fits
`ifdef BCD_REDUCER_CHECK_EN
  ,
  output logic           out_invalid
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] HIGH_CNT = CW'(N - M);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           hi_zero_q, hi_zero_d;
  logic           hi_nine_q, hi_nine_d;
  // The low register doubles as the output register: it only shifts while
  // collecting, so it is stable for the whole of HOLD.
  logic [4*M-1:0] low_q, low_d;
  logic           fits_q, fits_d;
  logic [4*M-1:0] low_shift;
  logic [3:0]     s_digit;
`ifdef BCD_REDUCER_CHECK_EN
  logic           bad_q, bad_d;
  logic           invalid_q, invalid_d;
`endif

  // New digit enters at the LSD end; the previous digits move up one place.
  generate
    if (M == 1) begin : g_shift_one
      assign low_shift = in_digit;
    end else begin : g_shift_many
      assign low_shift = {low_q[4*M-5:0], in_digit};
    end
  endgenerate

  // MSD of the low field once the final digit has been shifted in.
  assign s_digit = low_shift[4*M-1 -: 4];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      hi_zero_q <= 1'b1;
      hi_nine_q <= 1'b1;
      low_q     <= '0;
      fits_q    <= 1'b0;
`ifdef BCD_REDUCER_CHECK_EN
      bad_q     <= 1'b0;
      invalid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_zero_q <= hi_zero_d;
      hi_nine_q <= hi_nine_d;
      low_q     <= low_d;
      fits_q    <= fits_d;
`ifdef BCD_REDUCER_CHECK_EN
      bad_q     <= bad_d;
      invalid_q <= invalid_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_zero_d = hi_zero_q;
    hi_nine_d = hi_nine_q;
    low_d     = low_q;
    fits_d    = fits_q;
`ifdef BCD_REDUCER_CHECK_EN
    bad_d     = bad_q;
    invalid_d = invalid_q;
`endif
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (cnt_q < HIGH_CNT) begin
            hi_zero_d = hi_zero_q & (in_digit == 4'd0);
            hi_nine_d = hi_nine_q & (in_digit == 4'd9);
          end else begin
            low_d = low_shift;
          end
`ifdef BCD_REDUCER_CHECK_EN
          bad_d = bad_q | (in_digit > 4'd9);
`endif
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = HOLD;
            // The last digit is always a low digit, so the high flags are
            // already final here. Codes above 9 in s land on the negative side.
            fits_d  = (s_digit <= 4'd4) ? hi_zero_q : hi_nine_q;
`ifdef BCD_REDUCER_CHECK_EN
            if (bad_d) fits_d = 1'b0;
            invalid_d = bad_d;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = COLLECT;
          hi_zero_d = 1'b1;
          hi_nine_d = 1'b1;
`ifdef BCD_REDUCER_CHECK_EN
          bad_d     = 1'b0;
`endif
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready    = (state_q == COLLECT);
    out_valid   = (state_q == HOLD);
    out_digits  = low_q;
    out_fits    = fits_q;
`ifdef BCD_REDUCER_CHECK_EN
    out_invalid = invalid_q;
`endif
  end

endmodule
